// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
// State encoding, reset/exception vectors, next-PC source select.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'd0,
    NPC_BR  = 2'd1,
    NPC_JMP = 2'd2,
    NPC_JR  = 2'd3
  } npc_src_t;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
  localparam logic [31:0] PC_STEP    = 32'd4;

  function automatic logic misaligned(input logic [31:0] a);
    return (a[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/pc_sequencer_npc_select.sv
// Next-PC selection: priority mux jr > jmp > br_taken > PC+4.
// Ports: i_pc, redirect requests/targets in; o_npc, o_exc out.
// PC_ALIGN_CHECK_EN: misaligned redirect -> EXC_VECTOR, o_exc=1.
// Otherwise redirect targets are word-aligned by clearing bits[1:0].
module npc_select
  import pc_sequencer_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic        i_br_taken,
  input  logic [31:0] i_br_target,
  input  logic        i_jmp,
  input  logic [31:0] i_jmp_target,
  input  logic        i_jr,
  input  logic [31:0] i_jr_target,
  output logic [31:0] o_npc,
  output logic        o_exc
);

  npc_src_t    w_src;
  logic [31:0] w_tgt;
  logic [31:0] w_seq;

  // Wraps modulo 2^32 with no flag.
  assign w_seq = i_pc + PC_STEP;

  always_comb begin
    w_src = NPC_SEQ;
    w_tgt = w_seq;
    if (i_jr) begin
      w_src = NPC_JR;
      w_tgt = i_jr_target;
    end else if (i_jmp) begin
      w_src = NPC_JMP;
      w_tgt = i_jmp_target;
    end else if (i_br_taken) begin
      w_src = NPC_BR;
      w_tgt = i_br_target;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  // Sequential PC+4 is always aligned, so only redirects are checked.
  always_comb begin
    o_npc = w_tgt;
    o_exc = 1'b0;
    if (w_src != NPC_SEQ && misaligned(w_tgt)) begin
      o_npc = EXC_VECTOR;
      o_exc = 1'b1;
    end
  end
`else
  always_comb begin
    o_npc = w_tgt & ~32'h3;
    o_exc = 1'b0;
  end
`endif

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage controller owning the PC: imem req/ack handshake,
// instruction hand-off to decode, next-PC selection, halt.
// Ports: clk, reset (async high); imem_req/addr/ack/rdata;
// instr/instr_pc/instr_valid/dec_ready; br/jmp/jr redirects;
// halt/halted; exc_pulse. Optional macro: PC_ALIGN_CHECK_EN.
module pc_sequencer
  import pc_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        dec_ready,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        halt,
  output logic        halted,
  output logic        exc_pulse
);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic        r_exc;
  logic [31:0] w_npc;
  logic        w_exc;
  logic        w_take;
  logic        w_adv;
  logic        w_cap;

  npc_select u_npc (
    .i_pc         (r_pc),
    .i_br_taken   (br_taken),
    .i_br_target  (br_target),
    .i_jmp        (jmp),
    .i_jmp_target (jmp_target),
    .i_jr         (jr),
    .i_jr_target  (jr_target),
    .o_npc        (w_npc),
    .o_exc        (w_exc)
  );

  // Decode consumed the instruction; halt decides advance vs stop.
  assign w_take = (r_state == ST_VALID) && dec_ready;
  assign w_adv  = w_take && !halt;
  // Ack is only honoured while a request is outstanding.
  assign w_cap  = (r_state == ST_FETCH) && imem_ack;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  w_next = ST_FETCH;
      ST_FETCH: if (imem_ack) w_next = ST_VALID;
      ST_VALID: begin
        if (dec_ready) w_next = halt ? ST_HALT : ST_FETCH;
      end
      ST_HALT:  w_next = ST_HALT;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    unique case (r_state)
      ST_IDLE:  ;
      ST_FETCH: imem_req = 1'b1;
      ST_VALID: instr_valid = 1'b1;
      ST_HALT:  halted = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_exc      <= 1'b0;
    end else begin
      if (w_cap) begin
        r_instr    <= imem_rdata;
        r_instr_pc <= r_pc;
      end
      if (w_adv) r_pc <= w_npc;
      // High only during the FETCH cycle after the vector load.
      r_exc <= w_adv && w_exc;
    end
  end

  assign imem_addr = r_pc;
  assign instr     = r_instr;
  assign instr_pc  = r_instr_pc;
  assign exc_pulse = r_exc;

endmodule
